// File: rtl/board_link_tx.sv
// board_link_tx: sends a board snapshot to a peer over a four-phase nibble link.
//
// A session starts on a rising edge of the peer's request. The block then
// sends one header nibble followed by NCELLS cell nibbles read from the local
// board store. Each nibble is offered with valid and completed by the peer's
// ack_in rising and falling again.
//
// Ports
//   clk       in   sole clock; all logic runs on its rising edge
//   rst_n     in   asynchronous active-low reset
//   request   in   peer transfer request (asynchronous to clk)
//   ack_in    in   peer acknowledge of the current nibble (asynchronous to clk)
//   ack_out   out  request accepted; high for the whole session
//   data      out  nibble currently offered to the peer
//   valid     out  data is stable and offered
//   rd_en     out  one-cycle read strobe to the board store
//   rd_addr   out  cell index of the read
//   rd_data   in   cell value, valid one cycle after rd_en
//   busy      out  session in progress
//   done      out  one-cycle pulse when a session completes
//   error     out  one-cycle pulse on abort or timeout
module board_link_tx #(
    parameter logic [3:0] HEADER  = 4'hF,
    parameter int         NCELLS  = 81,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       request,
    input  logic       ack_in,
    output logic       ack_out,
    output logic [3:0] data,
    output logic       valid,
    output logic       rd_en,
    output logic [6:0] rd_addr,
    input  logic [3:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [6:0]     LAST_IDX = 7'(NCELLS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_RD = 3'd2,
        SEND    = 3'd3,
        RELEASE = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t         state_r;
    logic [6:0]     idx_r;
    logic [CW-1:0]  cnt_r;
    logic           req_meta_r;
    logic           req_s;
    logic           ack_meta_r;
    logic           ack_s;
    logic [1:0]     fill_r;
    logic           req_prev_r;
    logic           in_session_s;
    logic           timeout_s;
    logic           abort_s;
    logic           start_s;

    // Two-flop synchronizers plus the previous-request sample for edge detection.
    // req_prev_r is held high until the synchronizer has refilled after reset,
    // so a request that was already high across reset cannot start a session;
    // the peer must drop and raise it again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_r <= 1'b0;
            req_s      <= 1'b0;
            ack_meta_r <= 1'b0;
            ack_s      <= 1'b0;
            fill_r     <= 2'b00;
            req_prev_r <= 1'b1;
        end else begin
            req_meta_r <= request;
            req_s      <= req_meta_r;
            ack_meta_r <= ack_in;
            ack_s      <= ack_meta_r;
            fill_r     <= {fill_r[0], 1'b1};
            req_prev_r <= fill_r[1] ? req_s : 1'b1;
        end
    end

    assign in_session_s = (state_r == LOAD) || (state_r == WAIT_RD) ||
                          (state_r == SEND) || (state_r == RELEASE);
    assign timeout_s    = ((state_r == SEND) || (state_r == RELEASE)) && (cnt_r == CNT_MAX);
    // Abort wins over any handshake progress in the same cycle.
    assign abort_s      = in_session_s && (!req_s || timeout_s);
    assign start_s      = (state_r == IDLE) && req_s && !req_prev_r;

    // Session FSM with registered outputs and the handshake timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 7'd0;
            cnt_r   <= '0;
            ack_out <= 1'b0;
            data    <= 4'h0;
            valid   <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= 7'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            rd_en <= 1'b0;
            if (abort_s) begin
                state_r <= IDLE;
                valid   <= 1'b0;
                ack_out <= 1'b0;
                busy    <= 1'b0;
                error   <= 1'b1;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_s) begin
                            ack_out <= 1'b1;
                            busy    <= 1'b1;
                            idx_r   <= 7'd0;
                            state_r <= LOAD;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    LOAD: begin
                        // For cells the read strobe was already raised on entry,
                        // so the store answers while we sit in WAIT_RD.
                        if (idx_r == 7'd0) begin
                            data    <= HEADER;
                            valid   <= 1'b1;
                            cnt_r   <= '0;
                            state_r <= SEND;
                        end else begin
                            state_r <= WAIT_RD;
                        end
                    end
                    WAIT_RD: begin
                        data    <= rd_data;
                        valid   <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= SEND;
                    end
                    SEND: begin
                        if (ack_s) begin
                            valid   <= 1'b0;
                            cnt_r   <= '0;
                            state_r <= RELEASE;
                        end else begin
                            cnt_r   <= cnt_r + CNT_ONE;
                        end
                    end
                    RELEASE: begin
                        if (!ack_s) begin
                            cnt_r <= '0;
                            if (idx_r == LAST_IDX) begin
                                done    <= 1'b1;
                                state_r <= FINISH;
                            end else begin
                                // Next transfer idx+1 carries cell idx.
                                idx_r   <= idx_r + 7'd1;
                                rd_en   <= 1'b1;
                                rd_addr <= idx_r;
                                state_r <= LOAD;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    FINISH: begin
                        ack_out <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        valid   <= 1'b0;
                        ack_out <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_link_tx.sv
// Bench for board_link_tx: plays the peer board and the local board store,
// and compares the received nibble stream with header + store contents.
module tb_board_link_tx;

    localparam int         NC  = 81;
    localparam int         TO  = 16;
    localparam logic [3:0] HDR = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       request = 1'b0;
    logic       ack_in = 1'b0;
    logic       ack_out;
    logic [3:0] data;
    logic       valid;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [3:0] rd_data = 4'h0;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [0:127];

    // Written only by the monitor process.
    int         mon_viol = 0;
    int         err_hi   = 0;
    int         done_hi  = 0;
    int         rd_cnt   = 0;
    logic [3:0] prev_data = 4'h0;
    logic       prev_valid = 1'b0;

    board_link_tx #(.HEADER(HDR), .NCELLS(NC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .request(request), .ack_in(ack_in),
        .ack_out(ack_out), .data(data), .valid(valid), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Board store: answers a read one cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en === 1'b1) rd_data <= mem[rd_addr];
        else                rd_data <= 4'($urandom);
    end

    // Protocol monitor: data stability, read range, pulse bookkeeping.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && valid === 1'b1 && data !== prev_data) begin
                mon_viol <= mon_viol + 1;
                $display("protocol: data changed while valid (%h -> %h)", prev_data, data);
            end
            if (rd_en === 1'b1 && rd_addr > 7'(NC - 1)) begin
                mon_viol <= mon_viol + 1;
                $display("protocol: rd_addr %0d out of range", rd_addr);
            end
            if (done === 1'b1 && error === 1'b1) begin
                mon_viol <= mon_viol + 1;
                $display("protocol: done and error together");
            end
            if (error === 1'b1) err_hi  <= err_hi + 1;
            if (done === 1'b1)  done_hi <= done_hi + 1;
            if (rd_en === 1'b1) rd_cnt  <= rd_cnt + 1;
        end
        prev_valid <= rst_n & (valid === 1'b1);
        prev_data  <= data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic start_req();
        request = 1'b0;
        repeat (4) @(negedge clk);
        request = 1'b1;
    endtask

    // Peer side of one four-phase transfer.
    task automatic serve(input int d_ack, input int d_rel, output logic [3:0] nib, output bit ok);
        int n;
        ok  = 1'b1;
        nib = 4'h0;
        n   = 0;
        while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (valid !== 1'b1) begin ok = 1'b0; return; end
        nib = data;
        repeat (d_ack) @(negedge clk);
        ack_in = 1'b1;
        n = 0;
        while (valid !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (valid !== 1'b0) begin ok = 1'b0; ack_in = 1'b0; return; end
        repeat (d_rel) @(negedge clk);
        ack_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; request = 1'b0; ack_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack_out, data, valid, rd_en, rd_addr, busy, done, error} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ack_out, data, valid, rd_en, rd_addr, busy, done, error});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_full_session(input bit rnd);
        logic [3:0] exp_q[$];
        logic [3:0] got_q[$];
        logic [3:0] nib;
        bit ok;
        int d0, e0, r0;
        bit seen, ack_at_done, ack_after;
        for (int i = 0; i < NC; i++) mem[i] = rnd ? 4'($urandom) : 4'(i % 10);
        exp_q.push_back(HDR);
        for (int i = 0; i < NC; i++) exp_q.push_back(mem[i]);
        d0 = done_hi; e0 = err_hi; r0 = rd_cnt;
        start_req();
        for (int k = 0; k <= NC; k++) begin
            serve(rnd ? int'($urandom_range(0, 5)) : 3, rnd ? int'($urandom_range(0, 5)) : 3, nib, ok);
            if (!ok) break;
            got_q.push_back(nib);
        end
        seen = 1'b0; ack_at_done = 1'b0; ack_after = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                ack_at_done = ack_out;
                @(negedge clk);
                ack_after = ack_out;
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() != NC + 1) begin
            errors++; $display("FAIL session_len: got %0d transfers required %0d", got_q.size(), NC + 1);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL nibble_%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_hi - d0 != 1) begin errors++; $display("FAIL done_pulses: got %0d required 1", done_hi - d0); end
        checks++;
        if (err_hi - e0 != 0) begin errors++; $display("FAIL session_error: got %0d required 0", err_hi - e0); end
        checks++;
        if (rd_cnt - r0 != NC) begin errors++; $display("FAIL read_strobes: got %0d required %0d", rd_cnt - r0, NC); end
        checks++;
        if (ack_at_done !== 1'b1 || ack_after !== 1'b0) begin
            errors++; $display("FAIL ack_out_at_end: got %b,%b required 1,0", ack_at_done, ack_after);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b required 0", busy); end
    endtask

    task automatic test_no_restart();
        int busy_cycles = 0;
        request = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || valid !== 1'b0) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 0) begin errors++; $display("FAIL no_restart: got %0d busy cycles required 0", busy_cycles); end
    endtask

    task automatic test_back_to_back();
        test_full_session(1'b1);
    endtask

    task automatic test_abort();
        logic [3:0] nib;
        bit ok;
        int n, d0, e0;
        bit all_ok = 1'b1;
        start_req();
        for (int k = 0; k < 40; k++) begin
            serve(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), nib, ok);
            if (!ok) all_ok = 1'b0;
        end
        n = 0;
        while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!all_ok || valid !== 1'b1) begin
            errors++; $display("FAIL abort_reach_t40: got valid %b required 1", valid);
        end
        d0 = done_hi; e0 = err_hi;
        request = 1'b0;
        n = 0;
        while ((valid !== 1'b0 || ack_out !== 1'b0) && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n > 3 || valid !== 1'b0 || ack_out !== 1'b0) begin
            errors++; $display("FAIL abort_latency: got %0d cycles required <=3", n);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (err_hi - e0 != 1) begin errors++; $display("FAIL abort_error_pulse: got %0d required 1", err_hi - e0); end
        checks++;
        if (done_hi - d0 != 0) begin errors++; $display("FAIL abort_done: got %0d required 0", done_hi - d0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    endtask

    task automatic test_timeout();
        int n, hi;
        logic err_at_drop, busy_at_drop;
        start_req();
        n = 0;
        while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        hi = 0;
        while (valid === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
        err_at_drop  = error;
        busy_at_drop = busy;
        checks++;
        if (hi != TO) begin errors++; $display("FAIL timeout_cycles: got %0d required %0d", hi, TO); end
        checks++;
        if (err_at_drop !== 1'b1 || busy_at_drop !== 1'b0) begin
            errors++; $display("FAIL timeout_error: got err %b busy %b required 1 0", err_at_drop, busy_at_drop);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_width: got err %b valid %b required 0 0", error, valid);
        end
        request = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_session();
        logic [3:0] nib;
        bit ok;
        bit all_ok = 1'b1;
        int n, d0, e0, busy_cycles;
        start_req();
        for (int k = 0; k < 11; k++) begin
            serve(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), nib, ok);
            if (!ok) all_ok = 1'b0;
        end
        n = 0;
        while (valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!all_ok || data !== mem[10]) begin
            errors++; $display("FAIL cell10_data: got %h required %h", data, mem[10]);
        end
        ack_in = 1'b1;
        n = 0;
        while (valid !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack_out, data, valid, rd_en, rd_addr, busy, done, error} !== 17'd0) begin
            errors++; $display("FAIL async_reset_outputs: got %h required 0",
                               {ack_out, data, valid, rd_en, rd_addr, busy, done, error});
        end
        d0 = done_hi; e0 = err_hi;
        @(negedge clk);
        repeat (2) @(negedge clk);
        ack_in = 1'b0;
        rst_n  = 1'b1;
        busy_cycles = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 0) begin errors++; $display("FAIL held_request_after_reset: got %0d busy cycles required 0", busy_cycles); end
        checks++;
        if (done_hi - d0 != 0 || err_hi - e0 != 0) begin
            errors++; $display("FAIL reset_pulses: got done %0d error %0d required 0 0", done_hi - d0, err_hi - e0);
        end
        start_req();
        serve(2, 2, nib, ok);
        checks++;
        if (!ok || nib !== HDR) begin errors++; $display("FAIL restart_header: got %h required %h", nib, HDR); end
        request = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack_out !== 1'b0) begin
            errors++; $display("FAIL restart_abort_idle: got busy %b ack_out %b required 0 0", busy, ack_out);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (mon_viol != 0) begin errors++; $display("FAIL protocol_violations: got %0d required 0", mon_viol); end
    endtask

    initial begin
        test_reset();
        test_full_session(1'b0);
        test_no_restart();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_reset_mid_session();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
